// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle add/sub/logic/shift ops, an iterative
// shift-add multiply, and a condition-code register committed when a result is delivered.
module alu_seq #(
    parameter int W      = 64,
    parameter int MUL_EN = 1
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] aluA,
    input  logic [W-1:0] aluB,
    input  logic [3:0]   alufun,
    input  logic         set_cc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] valE,
    output logic [2:0]   cc,
    output logic         busy
);

    localparam int SH_W = $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_reg;
    logic [W-1:0]    val_reg;
    logic [W-1:0]    mcand_reg;
    logic [W-1:0]    mplier_reg;
    logic [SH_W-1:0] cnt_reg;
    logic            of_reg;
    logic            cc_en_reg;
    logic [2:0]      cc_reg;

    logic            accept;
    logic            deliver;
    logic            is_mul;
    logic [SH_W-1:0] sh_amt;
    logic [W-1:0]    sum;
    logic [W-1:0]    diff;
    logic            add_of;
    logic            sub_of;
    logic [W-1:0]    alu_res;
    logic            alu_of;
    logic [W-1:0]    mul_sum;

    assign out_valid = (state_reg == S_DONE);
    assign busy      = (state_reg == S_MUL);
    assign in_ready  = (state_reg == S_IDLE) || ((state_reg == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    assign is_mul    = (MUL_EN != 0) && (alufun == 4'd7);
    assign valE      = val_reg;
    assign cc        = cc_reg;

    assign sh_amt = aluA[SH_W-1:0];
    assign sum    = aluB + aluA;
    assign diff   = aluB - aluA;
    assign add_of = (aluA[W-1] == aluB[W-1]) && (sum[W-1] != aluA[W-1]);
    assign sub_of = (aluA[W-1] != aluB[W-1]) && (diff[W-1] != aluB[W-1]);

    // Codes 7 (when MUL is absent or routed to the iterative path) and 8-15 fall to ADD.
    always_comb begin
        alu_res = sum;
        alu_of  = add_of;
        case (alufun)
            4'd1: begin alu_res = diff;                          alu_of = sub_of; end
            4'd2: begin alu_res = aluB & aluA;                   alu_of = 1'b0;   end
            4'd3: begin alu_res = aluB ^ aluA;                   alu_of = 1'b0;   end
            4'd4: begin alu_res = aluB << sh_amt;                alu_of = 1'b0;   end
            4'd5: begin alu_res = aluB >> sh_amt;                alu_of = 1'b0;   end
            4'd6: begin alu_res = W'($signed(aluB) >>> sh_amt);  alu_of = 1'b0;   end
            default: ;
        endcase
    end

    // val_reg doubles as the multiply accumulator; it only has to be stable once in DONE.
    assign mul_sum = val_reg + (mplier_reg[0] ? mcand_reg : '0);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg  <= S_IDLE;
            val_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            of_reg     <= 1'b0;
            cc_en_reg  <= 1'b0;
            cc_reg     <= 3'b100;
        end else begin
            if (deliver && cc_en_reg)
                cc_reg <= {val_reg == '0, val_reg[W-1], of_reg};

            case (state_reg)
                S_IDLE: ;
                S_MUL: begin
                    val_reg    <= mul_sum;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == SH_W'(W - 1))
                        state_reg <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready && !in_valid)
                        state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase

            // A new operation overrides the DONE hold/release decided above.
            if (accept) begin
                cc_en_reg <= set_cc;
                if (is_mul) begin
                    state_reg  <= S_MUL;
                    val_reg    <= '0;
                    mcand_reg  <= aluB;
                    mplier_reg <= aluA;
                    cnt_reg    <= '0;
                    of_reg     <= 1'b0;
                end else begin
                    state_reg <= S_DONE;
                    val_reg   <= alu_res;
                    of_reg    <= alu_of;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (W=64, MUL_EN=1) with hand-computed results and flags.
module tb_alu_seq;

    logic        clock;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] aluA;
    logic [63:0] aluB;
    logic [3:0]  alufun;
    logic        set_cc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] valE;
    logic [2:0]  cc;
    logic        busy;

    int          n_vec;
    int          n_miss;
    logic [2:0]  exp_cc;

    alu_seq #(.W(64), .MUL_EN(1)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluA      (aluA),
        .aluB      (aluB),
        .alufun    (alufun),
        .set_cc    (set_cc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .valE      (valE),
        .cc        (cc),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic scramble_inputs();
        in_valid = 1'b0;
        aluA     = {$urandom, $urandom};
        aluB     = {$urandom, $urandom};
        alufun   = 4'($urandom);
        set_cc   = 1'($urandom);
    endtask

    // Issue one op with out_ready=1, wait for the result, check latency, value and cc.
    task automatic run_op(input string tag, input logic [3:0] fun, input logic [63:0] a,
                          input logic [63:0] b, input logic sc, input logic [63:0] exp_val,
                          input int exp_lat, input logic [2:0] flags);
        int lat;
        int busy_n;
        lat    = 0;
        busy_n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alufun    = fun;
        aluA      = a;
        aluB      = b;
        set_cc    = sc;
        chk({tag, "/in_ready"}, in_ready, 1);
        @(posedge clock);
        #1;
        scramble_inputs();
        do begin
            @(negedge clock);
            lat++;
            if (!out_valid) begin
                chk({tag, "/in_ready_busy"}, in_ready, 0);
                if (busy) busy_n++;
            end
        end while (!out_valid && lat < 200);
        chk({tag, "/latency"}, lat, exp_lat);
        chk({tag, "/busy_cycles"}, busy_n, exp_lat - 1);
        chk({tag, "/valE"}, valE, exp_val);
        @(posedge clock);
        #1;
        if (sc) exp_cc = flags;
        @(negedge clock);
        chk({tag, "/cc"}, cc, exp_cc);
        $display("%s: fun=%0d A=%h B=%h set_cc=%0b -> valE=%h lat=%0d cc=%b",
                 tag, fun, a, b, sc, exp_val, lat, cc);
    endtask

    initial begin
        int ghost;
        n_vec     = 0;
        n_miss    = 0;
        exp_cc    = 3'b100;
        resetn    = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        aluA      = '0;
        aluB      = '0;
        alufun    = '0;
        set_cc    = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b1;
        @(negedge clock);
        chk("rst/out_valid", out_valid, 0);
        chk("rst/valE", valE, 0);
        chk("rst/cc", cc, 3'b100);
        chk("rst/busy", busy, 0);
        chk("rst/in_ready", in_ready, 1);

        run_op("add_ovf",   4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000, 1, 3'b011);
        run_op("sub_zero",  4'd1, 64'd5, 64'd5, 1'b1, 64'd0, 1, 3'b100);
        run_op("add_nocc",  4'd0, 64'd0, 64'h8000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 1, 3'b010);
        run_op("sub_nocc",  4'd1, 64'd5, 64'd5, 1'b0, 64'd0, 1, 3'b100);
        run_op("sub_ovf",   4'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 3'b001);
        run_op("and",       4'd2, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1,
               64'h0F00_0F00_0F00_0F00, 1, 3'b000);
        run_op("xor",       4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 64'hFFFF_FFFF_FFFF_EDCB, 1, 3'b010);
        run_op("shl4",      4'd4, 64'd4, 64'd1, 1'b0, 64'h10, 1, 3'b000);
        run_op("shl64",     4'd4, 64'd64, 64'h1234, 1'b0, 64'h1234, 1, 3'b000);
        run_op("shl63",     4'd4, 64'd63, 64'd1, 1'b1, 64'h8000_0000_0000_0000, 1, 3'b010);
        run_op("shr",       4'd5, 64'd4, 64'hF000_0000_0000_0000, 1'b1, 64'h0F00_0000_0000_0000, 1, 3'b000);
        run_op("sar",       4'd6, 64'd4, 64'hF000_0000_0000_0000, 1'b1, 64'hFF00_0000_0000_0000, 1, 3'b010);
        run_op("fun9_add",  4'd9, 64'd2, 64'd3, 1'b1, 64'd5, 1, 3'b000);
        run_op("mul_3x5",   4'd7, 64'd3, 64'd5, 1'b1, 64'd15, 65, 3'b000);
        run_op("mul_neg",   4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 3'b010);

        // Stalled consumer, then same-cycle deliver/accept hand-off.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alufun    = 4'd0;
        aluA      = 64'd2;
        aluB      = 64'd3;
        set_cc    = 1'b1;
        chk("stall/in_ready", in_ready, 1);
        @(posedge clock);
        #1;
        scramble_inputs();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("stall/out_valid", out_valid, 1);
            chk("stall/valE", valE, 64'd5);
            chk("stall/in_ready", in_ready, 0);
            chk("stall/cc", cc, exp_cc);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alufun    = 4'd3;
        aluA      = 64'd7;
        aluB      = 64'd7;
        set_cc    = 1'b1;
        #1;
        chk("handoff/in_ready", in_ready, 1);
        @(posedge clock);
        #1;
        scramble_inputs();
        exp_cc = 3'b000;
        @(negedge clock);
        chk("handoff/out_valid", out_valid, 1);
        chk("handoff/valE", valE, 64'd0);
        chk("handoff/cc_first", cc, exp_cc);
        @(posedge clock);
        #1;
        exp_cc = 3'b100;
        @(negedge clock);
        chk("handoff/cc_second", cc, exp_cc);
        chk("handoff/out_valid_end", out_valid, 0);
        $display("handoff: ADD 2+3 held 10 cycles then XOR 7^7 -> cc=%b", cc);

        // Reset in the middle of a multiply.
        run_op("add_pre_rst", 4'd0, 64'd0, 64'h8000_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 1, 3'b010);
        in_valid = 1'b1;
        alufun   = 4'd7;
        aluA     = 64'd9;
        aluB     = 64'd9;
        set_cc   = 1'b1;
        chk("mrst/in_ready", in_ready, 1);
        @(posedge clock);
        #1;
        scramble_inputs();
        for (int i = 0; i < 19; i++) begin
            @(negedge clock);
            chk("mrst/busy", busy, 1);
        end
        @(posedge clock);
        #1;
        resetn = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        exp_cc = 3'b100;
        @(negedge clock);
        chk("mrst/out_valid", out_valid, 0);
        chk("mrst/busy", busy, 0);
        chk("mrst/cc", cc, exp_cc);
        chk("mrst/in_ready", in_ready, 1);
        chk("mrst/valE", valE, 64'd0);
        ghost = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clock);
            if (out_valid || busy) ghost++;
        end
        chk("mrst/no_ghost", ghost, 0);
        $display("mid_mul_reset: MUL 9x9 discarded at iteration 20, cc=%b", cc);

        run_op("add_post_rst", 4'd0, 64'd1, 64'd1, 1'b1, 64'd2, 1, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
